accum_bank: RTL and testbench

ACCUM_BANK -- requirements
Module: accum_bank

---
 rtl/accum_pkg.sv | 15 +
 rtl/accum_mul_seq.sv | 78 +++++++
 rtl/accum_bank.sv | 139 +++++++++++++
 tb/tb_accum_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - op-code constants and multiplier FSM state for the accumulator bank
package accum_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {IDLE, RUN} mul_state_e;

endpackage

// File: rtl/accum_mul_seq.sv
// rtl/accum_mul_seq.sv - sequential shift-add multiplier, low WIDTH bits, WIDTH busy cycles
module accum_mul_seq
  import accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] addend;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    valid    = 1'b0;
    addend   = mplier_q[0] ? mcand_q : '0;
    // result already includes the current step so the last step can be written directly
    result   = prod_q + addend;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = a;
          mplier_d = b;
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        prod_d   = result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          valid   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: rtl/accum_bank.sv
// rtl/accum_bank.sv - bank of NACC accumulators with ALU ops, flags and sequential multiply
module accum_bank
  import accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NACC  = 4,
  parameter int SAT   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [2:0]               op,
  input  logic [$clog2(NACC)-1:0]  sel,
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(NACC)-1:0]  rd_sel,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     accept,
  output logic                     busy,
  output logic                     done,
  output logic                     zero,
  output logic                     carry,
  output logic                     ovf
);

  localparam int SEL_W = $clog2(NACC);

  logic [WIDTH-1:0] acc_q [NACC];
  logic [WIDTH-1:0] acc_d [NACC];
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;
  logic [SEL_W-1:0] mul_sel_q, mul_sel_d;

  logic             mul_busy, mul_valid;
  logic [WIDTH-1:0] mul_result;
  logic [WIDTH-1:0] cur, res;
  logic [WIDTH:0]   sum, diff;
  logic             c, v, wr;

  assign accept = ena & ~mul_busy & ~rst;

  accum_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && (op == OP_MUL)),
    .a      (acc_q[sel]),
    .b      (data),
    .busy   (mul_busy),
    .result (mul_result),
    .valid  (mul_valid)
  );

  always_comb begin
    acc_d     = acc_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    mul_sel_d = mul_sel_q;
    cur       = acc_q[sel];
    sum       = {1'b0, cur} + {1'b0, data};
    diff      = {1'b0, cur} - {1'b0, data};
    res       = cur;
    c         = 1'b0;
    v         = 1'b0;
    wr        = 1'b0;
    if (accept) begin
      wr = 1'b1;
      case (op)
        OP_LOAD: res = data;
        OP_ADD: begin
          res = sum[WIDTH-1:0];
          c   = sum[WIDTH];
          v   = (cur[WIDTH-1] == data[WIDTH-1]) && (sum[WIDTH-1] != cur[WIDTH-1]);
          if (SAT != 0 && c) res = '1;
        end
        OP_SUB: begin
          res = diff[WIDTH-1:0];
          c   = diff[WIDTH];
          v   = (cur[WIDTH-1] != data[WIDTH-1]) && (diff[WIDTH-1] != cur[WIDTH-1]);
          if (SAT != 0 && c) res = '0;
        end
        OP_CLR: res = '0;
        OP_SHL: begin
          res = {cur[WIDTH-2:0], 1'b0};
          c   = cur[WIDTH-1];
        end
        OP_SHR: begin
          res = {cur[WIDTH-1], cur[WIDTH-1:1]};
          c   = cur[0];
        end
        OP_MUL: begin
          wr        = 1'b0;
          mul_sel_d = sel;
        end
        default: wr = 1'b0;
      endcase
    end
    if (wr) begin
      acc_d[sel] = res;
      zero_d     = (res == '0);
      carry_d    = c;
      ovf_d      = v;
      done_d     = 1'b1;
    end
    // accept is low while the multiplier runs, so this never collides with the write above
    if (mul_valid) begin
      acc_d[mul_sel_q] = mul_result;
      zero_d           = (mul_result == '0);
      carry_d          = 1'b0;
      ovf_d            = 1'b0;
      done_d           = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '{default: '0};
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      mul_sel_q <= '0;
    end else begin
      acc_q     <= acc_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      mul_sel_q <= mul_sel_d;
    end
  end

  assign rd_data = acc_q[rd_sel];
  assign busy    = mul_busy;
  assign done    = done_q;
  assign zero    = zero_q;
  assign carry   = carry_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_accum_bank.sv
// tb/tb_accum_bank.sv - scoreboard bench for accum_bank, wrapping (SAT=0) and saturating (SAT=1) instances
module tb_accum_bank;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, ADD = 3'b010, SUB = 3'b011;
  localparam logic [2:0] CLR = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] acc;
    logic       z, c, v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena0 = 1'b0, ena1 = 1'b0;
  logic [2:0] op = NOP;
  logic [1:0] sel = '0;
  logic [7:0] data = '0;
  logic [1:0] rd_sel0 = '0, rd_sel1 = '0;
  logic [7:0] rd_data0, rd_data1;
  logic       accept0, busy0, done0, zero0, carry0, ovf0;
  logic       accept1, busy1, done1, zero1, carry1, ovf1;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  accum_bank #(.WIDTH(8), .NACC(4), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena0), .op(op), .sel(sel), .data(data),
    .rd_sel(rd_sel0), .rd_data(rd_data0), .accept(accept0), .busy(busy0),
    .done(done0), .zero(zero0), .carry(carry0), .ovf(ovf0)
  );

  accum_bank #(.WIDTH(8), .NACC(4), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena1), .op(op), .sel(sel), .data(data),
    .rd_sel(rd_sel1), .rd_data(rd_data1), .accept(accept1), .busy(busy1),
    .done(done1), .zero(zero1), .carry(carry1), .ovf(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) check("spurious_done0", done0, 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        rd_sel0 = e.sel;
        #1;
        check("acc0", rd_data0, e.acc);
        check("zero0", zero0, e.z);
        check("carry0", carry0, e.c);
        check("ovf0", ovf0, e.v);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) check("spurious_done1", done1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        rd_sel1 = e.sel;
        #1;
        check("acc1", rd_data1, e.acc);
        check("zero1", zero1, e.z);
        check("carry1", carry1, e.c);
        check("ovf1", ovf1, e.v);
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] o, input logic [1:0] s, input logic [7:0] dat,
                       input bit push, input logic [7:0] eacc, input bit ez, input bit ec, input bit ev);
    exp_t e;
    @(negedge clk);
    op = o; sel = s; data = dat;
    if (d == 0) ena0 = 1'b1; else ena1 = 1'b1;
    #2;
    check("accept", (d == 0) ? accept0 : accept1, 1);
    e.sel = s; e.acc = eacc; e.z = ez; e.c = ec; e.v = ev;
    if (push) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    ena0 = 1'b0; ena1 = 1'b0; op = NOP;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
  endtask

  initial begin
    int nbusy;
    int ndone;

    // reset: ena held high must not be accepted
    rst = 1'b1; ena0 = 1'b1; ena1 = 1'b1; op = LOAD; data = 8'hAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_accept0", accept0, 0);
    check("rst_accept1", accept1, 0);
    check("rst_busy0", busy0, 0);
    check("rst_flags0", {zero0, carry0, ovf0, done0}, 0);
    for (int i = 0; i < 4; i++) begin
      rd_sel0 = 2'(i);
      #1;
      check("rst_acc", rd_data0, 0);
    end
    ena0 = 1'b0; ena1 = 1'b0; op = NOP;
    @(posedge clk);
    #1 rst = 1'b0;

    issue(0, LOAD, 2'd0, 8'h55, 1, 8'h55, 0, 0, 0);
    issue(0, LOAD, 2'd1, 8'h7F, 1, 8'h7F, 0, 0, 0);
    issue(0, ADD,  2'd1, 8'h01, 1, 8'h80, 0, 0, 1);
    issue(0, SUB,  2'd2, 8'h01, 1, 8'hFF, 0, 1, 0);
    issue(0, ADD,  2'd2, 8'h20, 1, 8'h1F, 0, 1, 0);
    issue(1, SUB,  2'd2, 8'h01, 1, 8'h00, 1, 1, 0);
    issue(1, LOAD, 2'd1, 8'hF0, 1, 8'hF0, 0, 0, 0);
    issue(1, ADD,  2'd1, 8'h20, 1, 8'hFF, 0, 1, 0);
    issue(0, NOP,  2'd0, 8'h99, 0, 8'h00, 0, 0, 0);
    drain();
    @(negedge clk);
    rd_sel0 = 2'd0;
    #1 check("acc0_untouched", rd_data0, 8'h55);
    rd_sel0 = 2'd1;
    #1 check("acc1_after_add", rd_data0, 8'h80);

    // multiply, with a request dropped while busy
    issue(0, LOAD, 2'd3, 8'h0C, 1, 8'h0C, 0, 0, 0);
    issue(0, MUL,  2'd3, 8'h0D, 1, 8'h9C, 0, 0, 0);
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ena0 = 1'b0;
      #2;
      if (busy0) nbusy++;
      if (i == 2) begin
        op = LOAD; sel = 2'd3; data = 8'hAA; ena0 = 1'b1;
        #1 check("accept_while_busy", accept0, 0);
      end
    end
    ena0 = 1'b0; op = NOP;
    check("mul_busy_cycles", nbusy, 8);
    drain();

    // reset in multiply cycle 4
    issue(0, MUL, 2'd3, 8'h02, 0, 8'h00, 0, 0, 0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    rd_sel0 = 2'd3;
    #1 check("abort_acc3", rd_data0, 8'h00);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    check("abort_no_done", ndone, 0);

    issue(0, LOAD, 2'd0, 8'h81, 1, 8'h81, 0, 0, 0);
    issue(0, SHR,  2'd0, 8'h00, 1, 8'hC0, 0, 1, 0);
    issue(0, SHL,  2'd0, 8'h00, 1, 8'h80, 0, 1, 0);
    issue(0, CLR,  2'd0, 8'h00, 1, 8'h00, 1, 0, 0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
